// File: rtl/sram_sky130_port_ctrl.sv
// Initiator-side port controller for the single-port sky130 SRAM macro.
// Turns a valid/ready request stream into macro cycles and queues read data in a credit-guarded FIFO.
module sram_sky130_port_ctrl #(
    parameter int DATA_BIT   = 32,
    parameter int ADDR_BIT   = 8,
    parameter int RSP_DEPTH  = 4,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_BIT-1:0] req_addr,
    input  logic [DATA_BIT-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_BIT-1:0] rsp_rdata,
    output logic                csb0,
    output logic                web0,
    output logic [ADDR_BIT-1:0] addr0,
    output logic [DATA_BIT-1:0] din0,
    input  logic [DATA_BIT-1:0] dout0,
    output logic                busy
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(RSP_DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_BIT-1:0] sweep_cnt;

    // rd_pipe[0]: read issued last posedge; rd_pipe[1]: macro has sampled it, dout0 valid next posedge
    logic [1:0]          rd_pipe;
    logic [1:0]          in_flight;
    logic [CNT_W:0]      credit_used;

    logic [DATA_BIT-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    fifo_count;

    logic                req_fire;
    logic                push;
    logic                pop;

    assign in_flight   = {1'b0, rd_pipe[0]} + {1'b0, rd_pipe[1]};
    assign credit_used = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(in_flight);

    assign req_fire = req_valid && req_ready;
    assign push     = rd_pipe[1];
    assign pop      = rsp_valid && rsp_ready;

    assign rsp_valid = (fifo_count != '0);
    assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : '0;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = (in_flight != 2'd0) || (fifo_count != '0);
        case (state_q)
            ST_INIT: begin
                busy = 1'b1;
                if (&sweep_cnt) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Credit counts reads already in flight so a capture always has a free slot.
                req_ready = (credit_used < CREDIT_MAX);
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cnt <= '0;
        end else if (state_q == ST_INIT) begin
            sweep_cnt <= sweep_cnt + ADDR_BIT'(1);
        end
    end

    // ------------------------------------------------------------------
    // Macro port registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb0  <= 1'b1;
            web0  <= 1'b1;
            addr0 <= '0;
            din0  <= '0;
        end else if (state_q == ST_INIT) begin
            csb0  <= 1'b0;
            web0  <= 1'b0;
            addr0 <= sweep_cnt;
            din0  <= '0;
        end else if (req_fire) begin
            csb0  <= 1'b0;
            web0  <= ~req_wen;
            addr0 <= req_addr;
            if (req_wen) begin
                din0 <= req_wdata;
            end
        end else begin
            csb0 <= 1'b1;
            web0 <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe <= 2'b00;
        end else begin
            rd_pipe <= {rd_pipe[0], req_fire && !req_wen};
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; fifo_count gates rsp_rdata to
    // zero while empty, so stale entries are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= dout0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_sky130_port_ctrl.sv
// Directed bench for sram_sky130_port_ctrl with a behavioural sky130 macro model
// and a read-response scoreboard fed from a reference copy of the memory.
module tb_sram_sky130_port_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wen;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          csb0;
    logic          web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;
    logic          busy;

    sram_sky130_port_ctrl #(
        .DATA_BIT  (DW),
        .ADDR_BIT  (AW),
        .RSP_DEPTH (4),
        .INIT_CLEAR(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wen  (req_wen),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .csb0     (csb0),
        .web0     (web0),
        .addr0    (addr0),
        .din0     (din0),
        .dout0    (dout0),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Macro model: inputs registered on posedge, array access on the following negedge.
    logic [DW-1:0] macro_mem [256];
    logic          m_csb;
    logic          m_web;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    bit            mem_seeded = 1'b0;

    always @(posedge clk) begin
        m_csb  <= csb0;
        m_web  <= web0;
        m_addr <= addr0;
        m_din  <= din0;
    end

    always @(negedge clk) begin
        if (!mem_seeded) begin
            for (int i = 0; i < 256; i++) macro_mem[i] = 32'hA5A5_0000 | 32'(i);
            mem_seeded = 1'b1;
        end
        if (m_csb === 1'b0) begin
            if (m_web === 1'b0) macro_mem[m_addr] = m_din;
            else dout0 <= macro_mem[m_addr];
        end
    end

    // Scoreboard state
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            n_rsp = 0;
    int            last_acc_cyc = 0;
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_q [$];
    int            pop_log [$];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: bookkeeping at negedge, then resume #1 after the posedge.
    task automatic tick();
        @(negedge clk);
        if (req_valid && req_ready) begin
            if (req_wen) ref_mem[req_addr] = req_wdata;
            else exp_q.push_back(ref_mem[req_addr]);
            last_acc_cyc = cyc;
        end
        if (rsp_valid && rsp_ready) begin
            check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("rsp_data", 64'(rsp_rdata), 64'(exp_q.pop_front()));
            n_rsp++;
            pop_log.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waits);
        logic acc;
        int   k;
        k = 0;
        req_valid = 1'b1;
        req_wen   = w;
        req_addr  = a;
        req_wdata = d;
        do begin
            acc = req_ready;
            tick();
            k++;
        end while (!acc && k < 40);
        check("send_accept", 64'(acc), 64'd1);
        waits = k - 1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_wen   = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        idle();
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && k < 60) begin
            tick();
            k++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_not_busy", 64'(busy), 64'd0);
    endtask

    task automatic init_sweep(input string tag);
        for (int i = 0; i < 256; i++) begin
            tick();
            check({tag, "_port"}, {22'd0, csb0, web0, addr0, din0}, {22'd0, 2'b00, 8'(i), 32'h0});
            if (i < 255) check({tag, "_ready_low"}, 64'(req_ready), 64'd0);
        end
        tick();
        check({tag, "_csb_released"}, 64'(csb0), 64'd1);
        check({tag, "_ready_high"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        int w;
        int wsum;
        int acc_n;
        int k;
        int rsp_before;
        int rd0_cyc;
        logic a;

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_port", {22'd0, csb0, web0, addr0, din0}, {22'd0, 2'b11, 8'h00, 32'h0});
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp", {31'd0, rsp_valid, rsp_rdata}, 64'd0);
        check("rst_busy_init", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero-fill sweep, then a cleared location reads back zero
        init_sweep("init");
        send(1'b0, 8'h7F, '0, w);
        drain();

        // Write, idle, read: response visible exactly two cycles after accept
        send(1'b1, 8'h05, 32'hDEAD_BEEF, w);
        idle();
        tick();
        send(1'b0, 8'h05, '0, w);
        idle();
        check("lat_n0_invalid", 64'(rsp_valid), 64'd0);
        tick();
        check("lat_n1_invalid", 64'(rsp_valid), 64'd0);
        tick();
        check("lat_n2_valid", 64'(rsp_valid), 64'd1);
        check("lat_n2_data", 64'(rsp_rdata), 64'hDEAD_BEEF);
        drain();

        // Back-to-back writes then reads, one per cycle
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 8'(i), 32'(i) * 32'h0101_0101, w);
            wsum += w;
        end
        pop_log.delete();
        rd0_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 8'(i), '0, w);
            if (i == 0) rd0_cyc = last_acc_cyc;
            wsum += w;
        end
        check("b2b_ready_never_dropped", 64'(wsum), 64'd0);
        drain();
        check("b2b_rsp_count", 64'(pop_log.size()), 64'd8);
        if (pop_log.size() == 8) begin
            check("b2b_first_rsp_cycle", 64'(pop_log[0]), 64'(rd0_cyc + 3));
            for (int i = 1; i < 8; i++) check("b2b_rsp_consecutive", 64'(pop_log[i]), 64'(pop_log[0] + i));
        end

        // Back-pressure: only RSP_DEPTH reads accepted while the consumer stalls
        rsp_ready  = 1'b0;
        rsp_before = n_rsp;
        acc_n      = 0;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_wen   = 1'b0;
            req_addr  = 8'(acc_n + 1);
            a = req_ready;
            tick();
            if (a) acc_n++;
        end
        check("bp_accepted", 64'(acc_n), 64'd4);
        check("bp_ready_low", 64'(req_ready), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bp_head_data", 64'(rsp_rdata), 64'h0101_0101);
        check("bp_busy", 64'(busy), 64'd1);
        rsp_ready = 1'b1;
        k = 0;
        while (acc_n < 6 && k < 30) begin
            req_addr = 8'(acc_n + 1);
            a = req_ready;
            tick();
            if (a) acc_n++;
            k++;
        end
        idle();
        check("bp_all_accepted", 64'(acc_n), 64'd6);
        drain();
        check("bp_rsp_count", 64'(n_rsp - rsp_before), 64'd6);

        // Read-after-write on consecutive cycles
        send(1'b1, 8'h10, 32'h1234_5678, w);
        send(1'b0, 8'h10, '0, w);
        idle();
        k = 0;
        while (!rsp_valid && k < 10) begin
            tick();
            k++;
        end
        check("raw_rsp_valid", 64'(rsp_valid), 64'd1);
        check("raw_data", 64'(rsp_rdata), 64'h1234_5678);
        drain();

        // Reset with two reads in flight and one captured entry
        rsp_ready = 1'b0;
        send(1'b0, 8'h01, '0, w);
        send(1'b0, 8'h02, '0, w);
        send(1'b0, 8'h03, '0, w);
        idle();
        check("mid_fifo_has_entry", 64'(rsp_valid), 64'd1);
        check("mid_fifo_csb_active", 64'(csb0), 64'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_csb0", 64'(csb0), 64'd1);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        exp_q.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        rsp_ready = 1'b1;
        rsp_before = n_rsp;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        init_sweep("reinit");
        check("mid_no_stale_rsp", 64'(n_rsp - rsp_before), 64'd0);
        send(1'b0, 8'h02, '0, w);
        drain();
        check("mid_one_fresh_rsp", 64'(n_rsp - rsp_before), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
